// File: rtl/hub_pkg.sv
// hub_pkg: shared definitions for the hub repeater core.
//   state_e    - repeater state encoding (idle / repeat one source / jam all)
//   JAM_NIBBLE - nibble driven on every port while jamming
package hub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REPEAT = 2'd1,
    ST_JAM    = 2'd2
  } state_e;

  localparam logic [3:0] JAM_NIBBLE = 4'h5;

endpackage

// File: rtl/hub_core_if.sv
// hub_core_if: MII-level bundle between the elastic buffers / internal PHYs
// and the repeater core.
//   rx_dv, rx_er, rxd  - per-port receive side (rxd packed 4 bits per port)
//   tx_en, tx_er, txd  - per-port transmit side (same packing as rxd)
//   jam, activity      - hub status for LEDs
// master: drives receive side, observes transmit side and status.
// slave : the repeater core.
interface hub_core_if #(
  parameter int PORT_COUNT = 4
);
  logic [PORT_COUNT-1:0]   rx_dv;
  logic [PORT_COUNT-1:0]   rx_er;
  logic [4*PORT_COUNT-1:0] rxd;
  logic [PORT_COUNT-1:0]   tx_en;
  logic [PORT_COUNT-1:0]   tx_er;
  logic [4*PORT_COUNT-1:0] txd;
  logic                    jam;
  logic                    activity;

  modport master (
    output rx_dv, rx_er, rxd,
    input  tx_en, tx_er, txd, jam, activity
  );

  modport slave (
    input  rx_dv, rx_er, rxd,
    output tx_en, tx_er, txd, jam, activity
  );
endinterface

// File: rtl/hub_port_arbiter.sv
// hub_port_arbiter: combinational classification of the per-port carrier.
//   i_rx_dv  - per-port receive data valid
//   i_k      - port index currently being repeated
//   o_none   - no port active
//   o_one    - exactly one port active
//   o_many   - two or more ports active
//   o_idx    - index of the active port (meaningful only when o_one)
//   o_other  - some port other than i_k is active
module hub_port_arbiter #(
  parameter int PORT_COUNT = 4,
  parameter int IDX_W      = 2
) (
  input  logic [PORT_COUNT-1:0] i_rx_dv,
  input  logic [IDX_W-1:0]      i_k,
  output logic                  o_none,
  output logic                  o_one,
  output logic                  o_many,
  output logic [IDX_W-1:0]      o_idx,
  output logic                  o_other
);

  int w_cnt;

  always_comb begin
    w_cnt   = 0;
    o_idx   = '0;
    o_other = 1'b0;
    for (int i = 0; i < PORT_COUNT; i++) begin
      if (i_rx_dv[i]) begin
        w_cnt = w_cnt + 1;
        o_idx = IDX_W'(i);
        if (i != int'(i_k)) o_other = 1'b1;
      end
    end
    o_none = (w_cnt == 0);
    o_one  = (w_cnt == 1);
    o_many = (w_cnt >= 2);
  end

endmodule

// File: rtl/hub_core.sv
// hub_core: MII repeater engine. Repeats a lone active port to all other
// ports, jams every port when two or more ports contend, and reports
// activity/jam status. All outputs are registered (1 clock latency) and are
// computed from the next state together with the current inputs.
//   clk   - 125 MHz system clock
//   rst_n - asynchronous active-low reset
//   bus   - hub_core_if slave modport (rx inputs, tx outputs, status)
module hub_core
  import hub_pkg::*;
#(
  parameter int PORT_COUNT = 4
) (
  input logic       clk,
  input logic       rst_n,
  hub_core_if.slave bus
);

  localparam int IDX_W = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;

  state_e                  r_state, w_next_state;
  logic [IDX_W-1:0]        r_src, w_next_src, w_idx;
  logic                    w_none, w_one, w_many, w_other;

  logic [PORT_COUNT-1:0]   r_tx_en, r_tx_er, w_tx_en, w_tx_er;
  logic [4*PORT_COUNT-1:0] r_txd, w_txd;
  logic                    r_jam, r_activity;
  int                      w_src_i;

  hub_port_arbiter #(
    .PORT_COUNT (PORT_COUNT),
    .IDX_W      (IDX_W)
  ) u_arb (
    .i_rx_dv (bus.rx_dv),
    .i_k     (r_src),
    .o_none  (w_none),
    .o_one   (w_one),
    .o_many  (w_many),
    .o_idx   (w_idx),
    .o_other (w_other)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_src   = r_src;
    case (r_state)
      ST_IDLE: begin
        if (w_many) begin
          w_next_state = ST_JAM;
        end else if (w_one) begin
          w_next_state = ST_REPEAT;
          w_next_src   = w_idx;
        end
      end
      // A new carrier on any other port is a collision, even if the
      // source has already dropped in the same cycle.
      ST_REPEAT: begin
        if (w_other)     w_next_state = ST_JAM;
        else if (w_none) w_next_state = ST_IDLE;
      end
      // Jam holds until the whole segment is quiet.
      ST_JAM: begin
        if (w_none) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_tx_en = '0;
    w_tx_er = '0;
    w_txd   = '0;
    w_src_i = int'(w_next_src);
    case (w_next_state)
      ST_REPEAT: begin
        for (int i = 0; i < PORT_COUNT; i++) begin
          if (i != w_src_i) begin
            w_tx_en[i]       = 1'b1;
            w_tx_er[i]       = bus.rx_er[w_src_i];
            w_txd[4*i +: 4]  = bus.rxd[4*w_src_i +: 4];
          end
        end
      end
      ST_JAM: begin
        w_tx_en = '1;
        w_txd   = {PORT_COUNT{JAM_NIBBLE}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_src      <= '0;
      r_tx_en    <= '0;
      r_tx_er    <= '0;
      r_txd      <= '0;
      r_jam      <= 1'b0;
      r_activity <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_src      <= w_next_src;
      r_tx_en    <= w_tx_en;
      r_tx_er    <= w_tx_er;
      r_txd      <= w_txd;
      r_jam      <= (w_next_state == ST_JAM);
      r_activity <= (w_next_state != ST_IDLE);
    end
  end

  assign bus.tx_en    = r_tx_en;
  assign bus.tx_er    = r_tx_er;
  assign bus.txd      = r_txd;
  assign bus.jam      = r_jam;
  assign bus.activity = r_activity;

endmodule

// File: tb/tb_hub_core.sv
// tb_hub_core: bench for hub_core with four ports. Directed vector table,
// hand-written reset/long-packet sequences and a randomized run against a
// behavioural model of the repeater rules.
module tb_hub_core;

  localparam int NP = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  hub_core_if #(.PORT_COUNT(NP)) bus ();

  hub_core #(.PORT_COUNT(NP)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: "jamming" flag and current owner port (-1 = none).
  bit m_jam;
  int m_owner;

  typedef struct {
    logic [3:0]  dv;
    logic [3:0]  er;
    logic [15:0] d;
    logic [3:0]  x_en;
    logic [3:0]  x_er;
    logic [15:0] x_txd;
    logic        x_jam;
    logic        x_act;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] en, input logic [3:0] er,
                           input logic [15:0] txd, input logic jam, input logic act);
    check({tag, "_tx_en"},    32'(bus.tx_en),    32'(en));
    check({tag, "_tx_er"},    32'(bus.tx_er),    32'(er));
    check({tag, "_txd"},      32'(bus.txd),      32'(txd));
    check({tag, "_jam"},      32'(bus.jam),      32'(jam));
    check({tag, "_activity"}, 32'(bus.activity), 32'(act));
  endtask

  task automatic model_update(input logic [3:0] dv);
    int n;
    logic [3:0] others;
    n = $countones(dv);
    if (m_jam) begin
      if (n == 0) m_jam = 1'b0;
    end else if (m_owner < 0) begin
      if (n >= 2) m_jam = 1'b1;
      else if (n == 1)
        for (int p = 0; p < NP; p++) if (dv[p]) m_owner = p;
    end else begin
      others = dv & ~(4'b0001 << m_owner);
      if (others != 4'b0) begin
        m_jam   = 1'b1;
        m_owner = -1;
      end else if (n == 0) begin
        m_owner = -1;
      end
    end
  endtask

  task automatic model_expect(input logic [3:0] er, input logic [15:0] d,
                              output logic [3:0] en_o, output logic [3:0] er_o,
                              output logic [15:0] txd_o, output logic jam_o, output logic act_o);
    en_o = 4'b0; er_o = 4'b0; txd_o = 16'h0; jam_o = 1'b0; act_o = 1'b0;
    if (m_jam) begin
      en_o = 4'hF; txd_o = 16'h5555; jam_o = 1'b1; act_o = 1'b1;
    end else if (m_owner >= 0) begin
      act_o = 1'b1;
      for (int p = 0; p < NP; p++) begin
        if (p != m_owner) begin
          en_o[p] = 1'b1;
          er_o[p] = er[m_owner];
          txd_o[4*p +: 4] = d[4*m_owner +: 4];
        end
      end
    end
  endtask

  // Apply inputs away from the edge, clock once, advance the model.
  task automatic step(input logic [3:0] dv, input logic [3:0] er, input logic [15:0] d);
    @(negedge clk);
    bus.rx_dv = dv;
    bus.rx_er = er;
    bus.rxd   = d;
    @(posedge clk);
    if (rst_n) model_update(dv);
    #1;
  endtask

  function automatic vec_t mk(logic [3:0] dv, logic [3:0] er, logic [15:0] d, logic [3:0] en,
                              logic [3:0] xer, logic [15:0] txd, logic jam, logic act);
    vec_t v;
    v.dv = dv; v.er = er; v.d = d; v.x_en = en; v.x_er = xer;
    v.x_txd = txd; v.x_jam = jam; v.x_act = act;
    return v;
  endfunction

  initial begin
    logic [3:0]  dv, er, e_en, e_er;
    logic [15:0] d, e_txd;
    logic        e_jam, e_act;
    int          r;

    checks = 0; errors = 0;
    m_jam = 1'b0; m_owner = -1;

    vecs[0]  = mk(4'b0000, 4'b0100, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 0, 0); // false carrier
    vecs[1]  = mk(4'b0010, 4'b0000, 16'h00A0, 4'b1101, 4'b0000, 16'hAA0A, 0, 1);
    vecs[2]  = mk(4'b0010, 4'b0000, 16'h00A0, 4'b1101, 4'b0000, 16'hAA0A, 0, 1);
    vecs[3]  = mk(4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 0, 0);
    vecs[4]  = mk(4'b0100, 4'b0100, 16'h0300, 4'b1011, 4'b1011, 16'h3033, 0, 1); // error prop
    vecs[5]  = mk(4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 0, 0);
    vecs[6]  = mk(4'b0001, 4'b0000, 16'h0007, 4'b1110, 4'b0000, 16'h7770, 0, 1);
    vecs[7]  = mk(4'b1001, 4'b0000, 16'h9007, 4'b1111, 4'b0000, 16'h5555, 1, 1); // collision
    vecs[8]  = mk(4'b1000, 4'b1000, 16'h9000, 4'b1111, 4'b0000, 16'h5555, 1, 1); // lone port stays jam
    vecs[9]  = mk(4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 0, 0);
    vecs[10] = mk(4'b0110, 4'b0000, 16'h0CB0, 4'b1111, 4'b0000, 16'h5555, 1, 1); // simultaneous start
    vecs[11] = mk(4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 0, 0);
    vecs[12] = mk(4'b0100, 4'b0000, 16'h0E00, 4'b1011, 4'b0000, 16'hE0EE, 0, 1);
    vecs[13] = mk(4'b0010, 4'b0000, 16'h00F0, 4'b1111, 4'b0000, 16'h5555, 1, 1); // swap of source
    vecs[14] = mk(4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 0, 0);

    rst_n = 1'b0;
    bus.rx_dv = '0; bus.rx_er = '0; bus.rxd = '0;
    repeat (3) @(posedge clk);
    #1 check_out("reset", 4'b0, 4'b0, 16'h0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].dv, vecs[i].er, vecs[i].d);
      check_out($sformatf("vec%0d", i), vecs[i].x_en, vecs[i].x_er, vecs[i].x_txd,
                vecs[i].x_jam, vecs[i].x_act);
    end

    // Long single-source packet.
    for (int i = 0; i < 10; i++) begin
      step(4'b0010, 4'b0000, 16'h00A0);
      check_out($sformatf("long%0d", i), 4'b1101, 4'b0, 16'hAA0A, 1'b0, 1'b1);
    end
    step(4'b0000, 4'b0000, 16'h0000);
    check_out("long_end", 4'b0, 4'b0, 16'h0, 1'b0, 1'b0);

    // Reset asserted mid-packet clears outputs without waiting for a clock.
    step(4'b0001, 4'b0000, 16'h000C);
    check_out("pre_rst", 4'b1110, 4'b0, 16'hCCC0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_out("async_rst", 4'b0, 4'b0, 16'h0, 1'b0, 1'b0);
    m_jam = 1'b0; m_owner = -1;
    step(4'b0001, 4'b0000, 16'h000C);
    check_out("rst_hold", 4'b0, 4'b0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    bus.rx_dv = '0; bus.rxd = '0;
    rst_n = 1'b1;
    step(4'b0000, 4'b0000, 16'h0000);
    check_out("rst_release", 4'b0, 4'b0, 16'h0, 1'b0, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      dv = 4'b0000;
      else if (r < 8) dv = 4'b0001 << $urandom_range(0, 3);
      else            dv = 4'($urandom);
      er = 4'($urandom);
      d  = 16'($urandom);
      step(dv, er, d);
      model_expect(er, d, e_en, e_er, e_txd, e_jam, e_act);
      check_out($sformatf("rand%0d", i), e_en, e_er, e_txd, e_jam, e_act);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
